mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory between the multi-cycle CPU
//  port (fetch and load/store through mem_adr/mem_in/mem_out) and a DMA/loader port.
//  Grants one transaction at a time, sequences the memory handshake and returns read
//  data plus a one-cycle ack to the granted requester.
//  Sits between the CPU core, the DMA engine and the memory model.
// PARAMETERS
//  FIXED_PRIO  0    0 = round-robin on ties; 1 = CPU always wins ties.
//  MEM_TO      255  Cycles in BUSY without mem_ready before abort (8-bit counter, 1..255).
//  CNT_W       16   Width of statistics counters (MEM_ARB_STATS_EN only).
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-low
//  cpu_req    in   1   CPU request; held with payload stable until cpu_ack
//  cpu_we     in   1   1 = write, 0 = read
//  cpu_adr    in   32  CPU byte address
//  cpu_wdata  in   32  CPU write data
//  cpu_rdata  out  32  read data, valid while cpu_ack = 1
//  cpu_ack    out  1   one-cycle completion pulse
//  cpu_err    out  1   with cpu_ack: transaction timed out
//  dma_req/dma_we/dma_adr/dma_wdata/dma_rdata/dma_ack/dma_err: DMA twins, same widths
//  mem_adr    out  32  memory address (registered)
//  mem_in     out  32  memory write data (registered)
//  mem_out    in   32  memory read data
//  mem_read   out  1   read strobe, held through BUSY
//  mem_write  out  1   write strobe, held through BUSY
//  mem_ready  in   1   memory completes access this cycle
//  owner      out  1   0 = CPU, 1 = DMA; last/current grantee
// BEHAVIOUR
//  Reset (rst = 0, async): state IDLE; all outputs 0; last_grant = DMA (CPU wins first tie).
//  States: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: sample reqs at edge. None: stay. One: grant it. Both: FIXED_PRIO=1 -> CPU;
//   else grantee != last_grant. On grant latch adr/wdata/we into mem_adr/mem_in,
//   set owner, last_grant, clear timeout counter; -> BUSY.
//  BUSY: mem_read = ~we, mem_write = we. mem_ready = 1 -> capture mem_out into the
//   grantee's rdata reg (reads only; writes leave rdata unchanged), -> RESP.
//   Counter reaches MEM_TO without mem_ready -> rdata = 32'hDEADBEEF, err flag, -> RESP.
//   mem_ready on the same cycle as timeout: ready wins, no err.
//  RESP: strobes 0; grantee ack = 1 (err as latched) for exactly this cycle; -> IDLE.
//  Latency: req seen at edge N -> BUSY cycle N+1; mem_ready there -> ack in cycle N+2.
//  Minimum 3 cycles between back-to-back grants (IDLE, BUSY, RESP); IDLE always
//   re-arbitrates, so a requester re-asserting immediately alternates with the other.
//  Requests deasserted mid-transaction are ignored; the granted access completes.
//  Never both acks in one cycle; strobes never both 1; strobes 0 outside BUSY.
//  Reset mid-BUSY aborts instantly: strobes drop, no ack issued.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds input stats_clr (1) and outputs cpu_grants,
//   dma_grants, conflict_cyc (CNT_W each). Grant counters +1 per IDLE->BUSY for that
//   port; conflict_cyc +1 every cycle a requester has req = 1 but is not granted
//   and not in RESP. Saturate at all-ones; stats_clr (sync) and rst zero them.
//  Undefined: these ports and counters do not exist; arbitration identical.
// TESTING
//  1 CPU read adr 0x40, mem_out 0x1234_5678, mem_ready in 1st BUSY cycle -> mem_read 1
//    cycle, cpu_ack in cycle N+2, cpu_rdata 0x1234_5678, cpu_err 0.
//  2 CPU and DMA req same cycle after reset, FIXED_PRIO=0 -> CPU first, DMA next,
//    owner 0 then 1; both held again -> CPU, DMA alternate.
//  3 FIXED_PRIO=1, both held for 4 transactions -> all CPU; DMA granted after CPU drops.
//  4 DMA write 0xCAFE_F00D to 0x100, mem_ready after 3 BUSY cycles -> mem_write high
//    3 cycles, mem_in 0xCAFE_F00D, dma_ack 1 cycle, dma_rdata unchanged.
//  5 MEM_TO=4, mem_ready held 0 -> after 4 BUSY cycles cpu_ack+cpu_err,
//    cpu_rdata 32'hDEADBEEF; rst low mid-BUSY -> strobes 0 immediately, no ack.
//  6 MEM_ARB_STATS_EN: 3 CPU, 2 DMA grants with one tie -> cpu_grants 3, dma_grants 2,
//    conflict_cyc > 0; stats_clr pulse -> all 0 next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one CPU or DMA transaction at a time on the shared memory.
// Define MEM_ARB_STATS_EN to add grant and conflict statistics counters.
module mem_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int MEM_TO     = 255,
   parameter int CNT_W      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_adr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   output logic        cpu_err,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_adr,
   input  logic [31:0] dma_wdata,
   output logic [31:0] dma_rdata,
   output logic        dma_ack,
   output logic        dma_err,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_in,
   input  logic [31:0] mem_out,
   output logic        mem_read,
   output logic        mem_write,
   input  logic        mem_ready,
   output logic        owner
`ifdef MEM_ARB_STATS_EN
  ,input  logic             stats_clr,
   output logic [CNT_W-1:0] cpu_grants,
   output logic [CNT_W-1:0] dma_grants,
   output logic [CNT_W-1:0] conflict_cyc
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;
   localparam logic [7:0]  TO_LAST = 8'(MEM_TO - 1);

   if (MEM_TO < 1 || MEM_TO > 255 || CNT_W < 1) begin : g_bad_param
      $error("mem_arbiter: MEM_TO must be 1..255 and CNT_W at least 1");
   end

   state_t      state_q;
   logic        last_q;
   logic        we_q;
   logic [7:0]  cnt_q;
   logic        req_any;
   logic        pick_dma;
   logic        sel_we;
   logic [31:0] sel_adr;
   logic [31:0] sel_wdata;
   logic        done;
   logic        upd_rdata;
   logic [31:0] rdata_d;

   // Ties go to the side that did not win last time unless CPU priority is fixed.
   assign req_any   = cpu_req | dma_req;
   assign pick_dma  = dma_req & (~cpu_req | (FIXED_PRIO == 0 && !last_q));
   assign sel_we    = pick_dma ? dma_we : cpu_we;
   assign sel_adr   = pick_dma ? dma_adr : cpu_adr;
   assign sel_wdata = pick_dma ? dma_wdata : cpu_wdata;
   assign done      = mem_ready || cnt_q == TO_LAST;
   assign upd_rdata = !mem_ready || !we_q;
   assign rdata_d   = mem_ready ? mem_out : TO_DATA;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         we_q      <= 1'b0;
         cnt_q     <= '0;
         owner     <= 1'b0;
         mem_adr   <= '0;
         mem_in    <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         cpu_rdata <= '0;
         cpu_ack   <= 1'b0;
         cpu_err   <= 1'b0;
         dma_rdata <= '0;
         dma_ack   <= 1'b0;
         dma_err   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req_any) begin
               state_q   <= BUSY;
               owner     <= pick_dma;
               last_q    <= pick_dma;
               we_q      <= sel_we;
               mem_read  <= ~sel_we;
               mem_write <= sel_we;
               mem_adr   <= sel_adr;
               mem_in    <= sel_wdata;
               cnt_q     <= '0;
            end
            BUSY: if (done) begin
               state_q   <= RESP;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               if (owner) begin
                  dma_ack <= 1'b1;
                  dma_err <= ~mem_ready;
                  if (upd_rdata) dma_rdata <= rdata_d;
               end else begin
                  cpu_ack <= 1'b1;
                  cpu_err <= ~mem_ready;
                  if (upd_rdata) cpu_rdata <= rdata_d;
               end
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
            RESP: begin
               state_q <= IDLE;
               cpu_ack <= 1'b0;
               cpu_err <= 1'b0;
               dma_ack <= 1'b0;
               dma_err <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic cpu_wait;
   logic dma_wait;

   // A requester waits while the other side is being granted or served.
   assign cpu_wait = cpu_req & (state_q == IDLE ? pick_dma : (state_q == BUSY) & owner);
   assign dma_wait = dma_req & (state_q == IDLE ? ~pick_dma : (state_q == BUSY) & ~owner);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return x + CNT_W'(~&x);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpu_grants   <= '0;
         dma_grants   <= '0;
         conflict_cyc <= '0;
      end else if (stats_clr) begin
         cpu_grants   <= '0;
         dma_grants   <= '0;
         conflict_cyc <= '0;
      end else begin
         if (state_q == IDLE && req_any && !pick_dma) cpu_grants <= sat_inc(cpu_grants);
         if (state_q == IDLE && pick_dma) dma_grants <= sat_inc(dma_grants);
         if (cpu_wait || dma_wait) conflict_cyc <= sat_inc(conflict_cyc);
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of a round-robin and a fixed-priority mem_arbiter.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_adr, cpu_wdata, dma_adr, dma_wdata, mem_out;
   logic        mem_ready;
   logic [7:0]  rdy_at;
   logic [7:0]  bcnt;

   logic [31:0] r_cpu_rdata, r_dma_rdata, r_mem_adr, r_mem_in;
   logic        r_cpu_ack, r_cpu_err, r_dma_ack, r_dma_err, r_mem_read, r_mem_write, r_owner;
   logic [31:0] f_cpu_rdata, f_dma_rdata, f_mem_adr, f_mem_in;
   logic        f_cpu_ack, f_cpu_err, f_dma_ack, f_dma_err, f_mem_read, f_mem_write, f_owner;
`ifdef MEM_ARB_STATS_EN
   logic        stats_clr;
   logic [15:0] r_cpu_grants, r_dma_grants, r_conflict, f_cpu_grants, f_dma_grants, f_conflict;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Memory model: ready on the rdy_at-th BUSY cycle, never when rdy_at is 0.
   always_ff @(posedge clk or negedge rst)
      if (!rst) bcnt <= '0;
      else bcnt <= (r_mem_read | r_mem_write) ? bcnt + 8'd1 : 8'd0;
   assign mem_ready = (r_mem_read | r_mem_write) && rdy_at != 8'd0 && bcnt == rdy_at - 8'd1;

   mem_arbiter #(.FIXED_PRIO(0), .MEM_TO(4), .CNT_W(16)) u_rr (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(r_cpu_rdata), .cpu_ack(r_cpu_ack), .cpu_err(r_cpu_err),
      .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
      .dma_rdata(r_dma_rdata), .dma_ack(r_dma_ack), .dma_err(r_dma_err),
      .mem_adr(r_mem_adr), .mem_in(r_mem_in), .mem_out(mem_out),
      .mem_read(r_mem_read), .mem_write(r_mem_write), .mem_ready(mem_ready), .owner(r_owner)
`ifdef MEM_ARB_STATS_EN
     ,.stats_clr(stats_clr), .cpu_grants(r_cpu_grants), .dma_grants(r_dma_grants),
      .conflict_cyc(r_conflict)
`endif
   );

   mem_arbiter #(.FIXED_PRIO(1), .MEM_TO(4), .CNT_W(16)) u_fp (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(f_cpu_rdata), .cpu_ack(f_cpu_ack), .cpu_err(f_cpu_err),
      .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
      .dma_rdata(f_dma_rdata), .dma_ack(f_dma_ack), .dma_err(f_dma_err),
      .mem_adr(f_mem_adr), .mem_in(f_mem_in), .mem_out(mem_out),
      .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_ready(mem_ready), .owner(f_owner)
`ifdef MEM_ARB_STATS_EN
     ,.stats_clr(stats_clr), .cpu_grants(f_cpu_grants), .dma_grants(f_dma_grants),
      .conflict_cyc(f_conflict)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_adr = '0; dma_wdata = '0;
      mem_out = '0; rdy_at = '0;
`ifdef MEM_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      step();
      step();
      check("rst_read", r_mem_read, 1'b0);
      check("rst_write", r_mem_write, 1'b0);
      check("rst_owner", r_owner, 1'b0);
      check("rst_ack", r_cpu_ack, 1'b0);
      check("rst_rdata", r_cpu_rdata, 32'h0);
      rst = 1'b1;

      // single CPU read, ready in the first BUSY cycle
      cpu_req = 1; cpu_we = 0; cpu_adr = 32'h40; mem_out = 32'h1234_5678; rdy_at = 8'd1;
      step();
      check("t1_read", r_mem_read, 1'b1);
      check("t1_write", r_mem_write, 1'b0);
      check("t1_adr", r_mem_adr, 32'h40);
      check("t1_owner", r_owner, 1'b0);
      check("t1_ack_early", r_cpu_ack, 1'b0);
      step();
      check("t1_ack", r_cpu_ack, 1'b1);
      check("t1_rdata", r_cpu_rdata, 32'h1234_5678);
      check("t1_err", r_cpu_err, 1'b0);
      check("t1_read_off", r_mem_read, 1'b0);
      check("t1_dma_ack", r_dma_ack, 1'b0);
      cpu_req = 0;
      step();
      check("t1_ack_end", r_cpu_ack, 1'b0);

      // both held: round-robin alternates, fixed priority stays on CPU
      do_reset();
      cpu_req = 1; dma_req = 1; cpu_we = 0; dma_we = 0;
      cpu_adr = 32'h10; dma_adr = 32'h20; mem_out = 32'h5A5A_0002;
      for (int k = 0; k < 4; k++) begin
         step();
         check("t2_owner", r_owner, (k % 2) == 1);
         check("t2_adr", r_mem_adr, (k % 2) == 1 ? 32'h20 : 32'h10);
         check("t3_owner", f_owner, 1'b0);
         step();
         check("t2_cpu_ack", r_cpu_ack, (k % 2) == 0);
         check("t2_dma_ack", r_dma_ack, (k % 2) == 1);
         check("t3_cpu_ack", f_cpu_ack, 1'b1);
         check("t3_dma_ack", f_dma_ack, 1'b0);
         step();
      end
      cpu_req = 0;
      step();
      check("t3_owner_dma", f_owner, 1'b1);
      check("t2_owner_dma", r_owner, 1'b1);
      step();
      check("t3_dma_ack_late", f_dma_ack, 1'b1);
      check("t3_dma_rdata", f_dma_rdata, 32'h5A5A_0002);
      dma_req = 0;
      step();

      // DMA write with ready on the third BUSY cycle
      dma_req = 1; dma_we = 1; dma_adr = 32'h100; dma_wdata = 32'hCAFE_F00D;
      mem_out = 32'hFFFF_FFFF; rdy_at = 8'd3;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t4_write", r_mem_write, 1'b1);
         check("t4_read", r_mem_read, 1'b0);
         check("t4_mem_in", r_mem_in, 32'hCAFE_F00D);
         check("t4_adr", r_mem_adr, 32'h100);
         check("t4_ack_early", r_dma_ack, 1'b0);
      end
      step();
      check("t4_ack", r_dma_ack, 1'b1);
      check("t4_err", r_dma_err, 1'b0);
      check("t4_write_off", r_mem_write, 1'b0);
      check("t4_rdata_kept", r_dma_rdata, 32'h5A5A_0002);
      check("t4_cpu_ack", r_cpu_ack, 1'b0);
      dma_req = 0;
      step();
      check("t4_ack_end", r_dma_ack, 1'b0);

      // timeout after MEM_TO busy cycles
      cpu_req = 1; cpu_we = 0; cpu_adr = 32'h200; rdy_at = 8'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t5_read", r_mem_read, 1'b1);
         check("t5_ack_early", r_cpu_ack, 1'b0);
      end
      step();
      check("t5_ack", r_cpu_ack, 1'b1);
      check("t5_err", r_cpu_err, 1'b1);
      check("t5_rdata", r_cpu_rdata, 32'hDEAD_BEEF);
      check("t5_read_off", r_mem_read, 1'b0);
      cpu_req = 0;
      step();
      check("t5_err_end", r_cpu_err, 1'b0);
      check("t5_ack_end", r_cpu_ack, 1'b0);

      // ready on the timeout cycle wins
      cpu_req = 1; rdy_at = 8'd4; mem_out = 32'h7777_0004;
      for (int i = 0; i < 4; i++) step();
      step();
      check("t5r_ack", r_cpu_ack, 1'b1);
      check("t5r_err", r_cpu_err, 1'b0);
      check("t5r_rdata", r_cpu_rdata, 32'h7777_0004);
      cpu_req = 0;
      step();

      // reset in the middle of BUSY
      cpu_req = 1; cpu_we = 1; cpu_wdata = 32'h0BAD_0001; rdy_at = 8'd0;
      step();
      check("t5b_write", r_mem_write, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("t5b_write_drop", r_mem_write, 1'b0);
      check("t5b_read_drop", r_mem_read, 1'b0);
      cpu_req = 0;
      step();
      check("t5b_no_ack", r_cpu_ack, 1'b0);
      rst = 1'b1;
      step();
      check("t5b_no_ack2", r_cpu_ack, 1'b0);
      check("t5b_idle", r_mem_write, 1'b0);

`ifdef MEM_ARB_STATS_EN
      do_reset();
      check("t6_rst_cpu", r_cpu_grants, 32'h0);
      cpu_req = 1; dma_req = 1; cpu_we = 0; dma_we = 0; rdy_at = 8'd1;
      for (int k = 0; k < 4; k++) repeat (3) step();
      dma_req = 0;
      repeat (3) step();
      cpu_req = 0;
      step();
      check("t6_cpu_grants", r_cpu_grants, 32'd3);
      check("t6_dma_grants", r_dma_grants, 32'd2);
      check("t6_conflict_nz", r_conflict != 16'd0, 1'b1);
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      check("t6_clr_cpu", r_cpu_grants, 32'h0);
      check("t6_clr_dma", r_dma_grants, 32'h0);
      check("t6_clr_conflict", r_conflict, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
